tx_serial_paridad: RTL and testbench

//  Downstream stage of the parity generator. Accepts a 7-bit word plus its parity bit,

---
 rtl/tx_serial_paridad.sv | 159 +++++++++++++++
 tb/tb_tx_serial_paridad.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial_paridad.sv
// Async serial transmitter: start, DATA_W data bits LSB first, parity, STOP_BITS stop bits.
// Optional build macro PARIDAD_CHECK_EN adds a sticky parity-mismatch check on captured words.
module tx_serial_paridad #(
    parameter int unsigned DATA_W    = 7,
    parameter int unsigned BAUD_DIV  = 4,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              paridad_in,
`ifdef PARIDAD_CHECK_EN
    input  logic              parimpar_in,
    output logic              err_paridad,
`endif
    output logic              ready_out,
    output logic              busy,
    output logic              tx_out
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [BW-1:0]     baud, baud_n;
    logic [CW-1:0]     bitcnt, bitcnt_n;
    logic [DATA_W:0]   shreg, shreg_n;
    logic              tx_n, ready_n, busy_n;
    logic              baud_wrap;
    logic              accept;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            baud      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            tx_out    <= 1'b1;
            ready_out <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            tx_out    <= tx_n;
            ready_out <= ready_n;
            busy      <= busy_n;
        end
    end

    // Outputs are computed for the state being entered so they leave registers directly.
    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        tx_n      = tx_out;
        ready_n   = ready_out;
        busy_n    = busy;
        baud_wrap = (baud == BAUD_LAST);
        accept    = 1'b0;

        if (state != IDLE) begin
            baud_n = baud_wrap ? '0 : baud + BW'(1);
        end

        unique case (state)
            IDLE: begin
                baud_n   = '0;
                bitcnt_n = '0;
                tx_n     = 1'b1;
                if (valid_in && ready_out) begin
                    accept  = 1'b1;
                    shreg_n = {paridad_in, data_in};
                    state_n = START;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    tx_n     = shreg[0];
                end
            end
            DATA: begin
                // After DATA_W shifts the parity bit sits at shreg[0], so the same tap feeds PARITY.
                if (baud_wrap) begin
                    shreg_n = shreg >> 1;
                    tx_n    = shreg[1];
                    if (bitcnt == DATA_LAST) begin
                        state_n  = PARITY;
                        bitcnt_n = '0;
                    end else begin
                        bitcnt_n = bitcnt + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_n  = STOP;
                    bitcnt_n = '0;
                    tx_n     = 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (bitcnt == STOP_LAST) begin
                        state_n  = IDLE;
                        bitcnt_n = '0;
                        ready_n  = 1'b1;
                        busy_n   = 1'b0;
                    end else begin
                        bitcnt_n = bitcnt + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

`ifdef PARIDAD_CHECK_EN
    logic par_exp;

    // Even parity makes the total count of ones even; odd inverts it.
    always_comb begin
        par_exp = (^data_in) ^ parimpar_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_paridad <= 1'b0;
        end else if (accept && (paridad_in != par_exp)) begin
            err_paridad <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_serial_paridad.sv
// Scoreboard bench for tx_serial_paridad: two instances (BAUD_DIV=4/STOP_BITS=1 and 1/2),
// expected line waveforms built from the frame format and compared sample by sample.
module tb_tx_serial_paridad;

    typedef struct {
        logic [63:0] smp;
        int          len;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [1:0] valid = '0;
    logic [6:0] data [2];
    logic [1:0] par = '0;
    logic [1:0] ready, busy, tx;
    logic [1:0] parimpar = '0;
`ifdef PARIDAD_CHECK_EN
    logic [1:0] err;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_serial_paridad #(.DATA_W(7), .BAUD_DIV(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid[0]), .data_in(data[0]),
        .paridad_in(par[0]),
`ifdef PARIDAD_CHECK_EN
        .parimpar_in(parimpar[0]), .err_paridad(err[0]),
`endif
        .ready_out(ready[0]), .busy(busy[0]), .tx_out(tx[0])
    );

    tx_serial_paridad #(.DATA_W(7), .BAUD_DIV(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset_L(reset_L), .valid_in(valid[1]), .data_in(data[1]),
        .paridad_in(par[1]),
`ifdef PARIDAD_CHECK_EN
        .parimpar_in(parimpar[1]), .err_paridad(err[1]),
`endif
        .ready_out(ready[1]), .busy(busy[1]), .tx_out(tx[1])
    );

    task automatic chk(input bit ok, input string nm, input int g,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s inst%0d actual=%0h expected=%0h (t=%0t)", nm, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int BD = (g == 0) ? 4 : 1;
        localparam int SB = (g == 0) ? 1 : 2;
        localparam int FL = (2 + 7 + SB) * BD;

        exp_t q[$];
        exp_t cur;
        int   cap = 0;
        int   pos = 0;

        function automatic logic [63:0] frame_of(input logic [6:0] d, input logic p);
            logic [63:0] r;
            int b;
            r = '1;
            for (int k = 0; k < FL; k++) begin
                b = k / BD;
                if (b == 0)      r[k] = 1'b0;
                else if (b <= 7) r[k] = d[b-1];
                else if (b == 8) r[k] = p;
                else             r[k] = 1'b1;
            end
            return r;
        endfunction

        always @(posedge clk) begin
            exp_t e;
            if (reset_L && valid[g] && ready[g]) begin
                e.smp = frame_of(data[g], par[g]);
                e.len = FL;
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end

        always @(negedge clk) begin
            if (!reset_L) begin
                chk({tx[g], ready[g], busy[g]} == 3'b110, "reset_state", g,
                    {61'd0, tx[g], ready[g], busy[g]}, 64'h6);
                cap = 0;
                q.delete();
            end else if (cap != 0) begin
                chk(tx[g] == cur.smp[pos], $sformatf("frame_bit%0d", pos), g,
                    {63'd0, tx[g]}, {63'd0, cur.smp[pos]});
                chk({ready[g], busy[g]} == 2'b01, "busy_flags", g,
                    {62'd0, ready[g], busy[g]}, 64'h1);
                pos++;
                if (pos >= cur.len) cap = 0;
            end else if (tx[g] == 1'b0) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_start", g, 64'd0, 64'd1);
                end else begin
                    cur = q.pop_front();
                    chk(cyc == cur.acc, "start_latency", g, 64'(cyc), 64'(cur.acc));
                    chk({ready[g], busy[g]} == 2'b01, "busy_flags", g,
                        {62'd0, ready[g], busy[g]}, 64'h1);
                    cap = 1;
                    pos = 1;
                end
            end else begin
                chk({ready[g], busy[g]} == 2'b10, "idle_flags", g,
                    {62'd0, ready[g], busy[g]}, 64'h2);
                if (q.size() != 0)
                    chk(q[0].acc > cyc, "missing_start", g, 64'(cyc), 64'(q[0].acc));
            end
        end
    end

    task automatic send(input int g, input logic [6:0] d, input logic p);
        int n = 0;
        while (!ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready[g]) chk(1'b0, "ready_timeout", g, 64'd0, 64'd1);
        data[g]  = d;
        par[g]   = p;
        valid[g] = 1'b1;
        @(negedge clk);
        valid[g] = 1'b0;
    endtask

    task automatic wait_ready(input int g);
        int n = 0;
        while (!ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(ready[g] == 1'b1, "wait_ready", g, {63'd0, ready[g]}, 64'd1);
    endtask

    task automatic random_phase(input int g, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            valid[g] = ($urandom_range(0, 3) == 0);
            data[g]  = 7'($urandom);
            par[g]   = 1'($urandom);
        end
        valid[g] = 1'b0;
        wait_ready(g);
    endtask

    initial begin
        data[0] = '0;
        data[1] = '0;

        // Reset held for 3 clocks.
        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        repeat (2) @(negedge clk);

        // Single 7'h55 frame, then ready one clock after the last stop clock.
        send(0, 7'h55, 1'b0);
        wait_ready(0);
        repeat (3) @(negedge clk);

        // Valid held high with 7'h7F; data scrambled whenever the block is busy.
        valid[0] = 1'b1;
        par[0]   = 1'b1;
        for (int i = 0; i < 3 * 41; i++) begin
            data[0] = ready[0] ? 7'h7F : 7'($urandom);
            @(negedge clk);
        end
        valid[0] = 1'b0;
        wait_ready(0);
        repeat (2) @(negedge clk);

        // Reset mid-frame while the line is low.
        send(0, 7'h00, 1'b0);
        repeat (14) @(posedge clk);
        #2;
        chk(tx[0] == 1'b0, "pre_reset_line", 0, {63'd0, tx[0]}, 64'd0);
        reset_L = 1'b0;
        #1;
        chk(tx[0] == 1'b1, "reset_tx_immediate", 0, {63'd0, tx[0]}, 64'd1);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        repeat (20) @(negedge clk);

        // Short-bit instance: 11-clock frame for 7'h01 with parity 1.
        send(1, 7'h01, 1'b1);
        wait_ready(1);
        repeat (2) @(negedge clk);

        random_phase(0, 500);
        random_phase(1, 200);

`ifdef PARIDAD_CHECK_EN
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        chk(err[0] == 1'b0, "err_after_reset", 0, {63'd0, err[0]}, 64'd0);
        parimpar[0] = 1'b0;
        send(0, 7'h03, 1'b1);
        chk(err[0] == 1'b1, "err_next_clock", 0, {63'd0, err[0]}, 64'd1);
        send(0, 7'h03, 1'b0);
        wait_ready(0);
        chk(err[0] == 1'b1, "err_sticky", 0, {63'd0, err[0]}, 64'd1);
        reset_L = 1'b0;
        @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        send(0, 7'h03, 1'b0);
        wait_ready(0);
        chk(err[0] == 1'b0, "err_good_parity", 0, {63'd0, err[0]}, 64'd0);
        parimpar[0] = 1'b1;
        send(0, 7'h03, 1'b1);
        wait_ready(0);
        chk(err[0] == 1'b0, "err_odd_ok", 0, {63'd0, err[0]}, 64'd0);
`endif

        repeat (50) @(negedge clk);
        chk(mon[0].q.size() == 0 && mon[0].cap == 0, "drained", 0,
            64'(mon[0].q.size()), 64'd0);
        chk(mon[1].q.size() == 0 && mon[1].cap == 0, "drained", 1,
            64'(mon[1].q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
